conv_input_loader: RTL

- Next-generation AXI-Stream input loader for the 2D convolution accelerator.
- Accepts a kernel set W (one KxK kernel per input channel), a scalar bias B and a multi-channel input image X.
- K, image rows and image columns are set at run time; the channel count is a parameter.
- Sits between the AXIS slave port and the conv datapath; presents 1-cycle-latency read ports for X and W once loading completes.

---
 rtl/conv_loader_pkg.sv | 23 ++
 rtl/conv_input_loader_bank.sv | 25 ++
 rtl/conv_input_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_loader_pkg.sv
// Shared types and helpers for the conv input loader: state encoding,
// tuser field positions and the run-time configuration legality check.
package conv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    LOAD_X,
    DONE
  } loader_state_t;

  localparam int NEWW_BIT = 0;
  localparam int K_LSB    = 1;

  function automatic logic cfg_ok(input int k, input int nrows, input int ncols,
                                  input int maxk, input int maxr, input int maxc);
    return (k >= 1) && (k <= maxk) &&
           (nrows >= 1) && (nrows <= maxr) &&
           (ncols >= 1) && (ncols <= maxc);
  endfunction

endpackage

// File: rtl/conv_input_loader_bank.sv
// Single-port synchronous RAM used for the X planes and W kernels.
// A write in a cycle takes priority; otherwise the addressed word is registered out.
module loader_bank #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 64,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/conv_input_loader.sv
// AXI-Stream input loader for the conv accelerator: loads W kernels, bias and X planes,
// then exposes 1-cycle read ports. Optional TLAST framing check: CONV_LOADER_TLAST_CHECK_EN.
module conv_input_loader
  import conv_loader_pkg::*;
#(
  parameter int INW  = 24,
  parameter int MAXK = 4,
  parameter int MAXR = 16,
  parameter int MAXC = 16,
  parameter int NCH  = 2,
  localparam int K_BITS  = $clog2(MAXK + 1),
  localparam int PLANE   = MAXR * MAXC,
  localparam int XA_BITS = $clog2(NCH * PLANE),
  localparam int WA_BITS = $clog2(NCH * MAXK * MAXK),
  localparam int CH_BITS = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int R_BITS  = $clog2(MAXR + 1),
  localparam int C_BITS  = $clog2(MAXC + 1),
  localparam int PA_BITS = $clog2(PLANE),
  localparam int KA_BITS = $clog2(MAXK * MAXK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INW-1:0]     s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [K_BITS:0]    s_axis_tuser,
  input  logic               s_axis_tlast,
  input  logic [R_BITS-1:0]  cfg_rows,
  input  logic [C_BITS-1:0]  cfg_cols,
  input  logic               compute_finished,
  output logic               inputs_loaded,
  output logic [K_BITS-1:0]  K,
  output logic [INW-1:0]     B,
  output logic [R_BITS-1:0]  rows,
  output logic [C_BITS-1:0]  cols,
  input  logic [CH_BITS-1:0] x_rd_ch,
  input  logic [PA_BITS-1:0] x_rd_addr,
  output logic [INW-1:0]     x_rd_data,
  input  logic [CH_BITS-1:0] w_rd_ch,
  input  logic [KA_BITS-1:0] w_rd_addr,
  output logic [INW-1:0]     w_rd_data,
  output logic               err_cfg,
  output logic               err_last
);

  localparam int KK_BITS = $clog2(MAXK * MAXK + 1);
  localparam int P_BITS  = $clog2(PLANE + 1);
  localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(NCH - 1);

  loader_state_t state, state_next;

  logic [K_BITS-1:0]  k_q;
  logic [INW-1:0]     b_q;
  logic [R_BITS-1:0]  rows_q;
  logic [C_BITS-1:0]  cols_q;
  logic               w_valid;
  logic               err_cfg_q;

  logic [KK_BITS-1:0] e;
  logic [P_BITS-1:0]  xe;
  logic [R_BITS-1:0]  r;
  logic [C_BITS-1:0]  c;
  logic [CH_BITS-1:0] ch;

  logic               new_w;
  logic [K_BITS-1:0]  tuser_k;
  logic               in_idle;
  logic [K_BITS-1:0]  cur_k;
  logic [R_BITS-1:0]  cur_rows;
  logic [C_BITS-1:0]  cur_cols;
  logic [KK_BITS-1:0] kk;
  logic [P_BITS-1:0]  plane_sz;
  logic               cfg_good;
  logic               beat, start_w, start_x, reject;
  logic               w_beat, b_beat, x_beat;
  logic               ch_last, e_wrap, x_wrap, col_wrap, x_final;
  logic               early_last, missing_last;

  logic [XA_BITS-1:0] x_wr_addr, x_rd_full, x_addr;
  logic [WA_BITS-1:0] w_wr_addr, w_rd_full, w_addr;

  assign new_w   = s_axis_tuser[NEWW_BIT];
  assign tuser_k = s_axis_tuser[K_LSB +: K_BITS];

  // In IDLE the incoming beat's configuration drives the checks and the
  // end-of-block compares, so single-element blocks finish on the first beat.
  always_comb begin
    in_idle  = (state == IDLE);
    cur_k    = (in_idle && new_w) ? tuser_k : k_q;
    cur_rows = in_idle ? cfg_rows : rows_q;
    cur_cols = in_idle ? cfg_cols : cols_q;
    kk       = KK_BITS'(cur_k) * KK_BITS'(cur_k);
    plane_sz = P_BITS'(cur_rows) * P_BITS'(cur_cols);
    cfg_good = cfg_ok(int'(cur_k), int'(cur_rows), int'(cur_cols), MAXK, MAXR, MAXC);

    beat     = s_axis_tvalid && s_axis_tready;
    start_w  = in_idle && beat && new_w && cfg_good;
    start_x  = in_idle && beat && !new_w && w_valid && cfg_good;
    reject   = in_idle && beat && !start_w && !start_x;
    w_beat   = start_w || ((state == LOAD_W) && beat);
    b_beat   = (state == LOAD_B) && beat;
    x_beat   = start_x || ((state == LOAD_X) && beat);

    ch_last  = (ch == CH_LAST);
    e_wrap   = (e == kk - KK_BITS'(1));
    x_wrap   = (xe == plane_sz - P_BITS'(1));
    col_wrap = (c == cur_cols - C_BITS'(1));
    x_final  = x_beat && x_wrap && ch_last;
  end

`ifdef CONV_LOADER_TLAST_CHECK_EN
  logic frame_w;
  logic err_last_q;

  assign early_last   = (w_beat || b_beat || x_beat) && s_axis_tlast && !x_final;
  assign missing_last = x_final && !s_axis_tlast;
  assign err_last     = err_last_q;
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign early_last   = 1'b0;
  assign missing_last = 1'b0;
  assign err_last     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_w) begin
          state_next = (e_wrap && ch_last) ? LOAD_B : LOAD_W;
        end else if (start_x) begin
          state_next = x_final ? DONE : LOAD_X;
        end
      end
      LOAD_W:  if (w_beat && e_wrap && ch_last) state_next = LOAD_B;
      LOAD_B:  if (b_beat) state_next = LOAD_X;
      LOAD_X:  if (x_final) state_next = DONE;
      DONE:    if (compute_finished) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (early_last) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    s_axis_tready = (state != DONE);
    inputs_loaded = (state == DONE);
  end

  // Counters, latched configuration and error flags; frame abort overrides the rest.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q       <= '0;
      b_q       <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      w_valid   <= 1'b0;
      err_cfg_q <= 1'b0;
      e         <= '0;
      xe        <= '0;
      r         <= '0;
      c         <= '0;
      ch        <= '0;
`ifdef CONV_LOADER_TLAST_CHECK_EN
      frame_w    <= 1'b0;
      err_last_q <= 1'b0;
`endif
    end else begin
      err_cfg_q <= reject;
      if (start_w) begin
        k_q <= tuser_k;
      end
      if (start_w || start_x) begin
        rows_q <= cfg_rows;
        cols_q <= cfg_cols;
      end
      if (w_beat) begin
        if (e_wrap) begin
          e  <= '0;
          ch <= ch_last ? '0 : ch + 1'b1;
        end else begin
          e <= e + 1'b1;
        end
      end
      if (b_beat) begin
        b_q     <= s_axis_tdata;
        w_valid <= 1'b1;
      end
      if (x_beat) begin
        if (x_wrap) begin
          xe <= '0;
          r  <= '0;
          c  <= '0;
          ch <= ch_last ? '0 : ch + 1'b1;
        end else begin
          xe <= xe + 1'b1;
          if (col_wrap) begin
            c <= '0;
            r <= r + 1'b1;
          end else begin
            c <= c + 1'b1;
          end
        end
      end
      if ((state == DONE) && compute_finished) begin
        e  <= '0;
        xe <= '0;
        r  <= '0;
        c  <= '0;
        ch <= '0;
      end
`ifdef CONV_LOADER_TLAST_CHECK_EN
      if (start_w) begin
        frame_w <= 1'b1;
      end else if (start_x) begin
        frame_w <= 1'b0;
      end
      if (missing_last) begin
        err_last_q <= 1'b1;
      end
      if (early_last) begin
        err_last_q <= 1'b1;
        e  <= '0;
        xe <= '0;
        r  <= '0;
        c  <= '0;
        ch <= '0;
        if (start_w || frame_w) begin
          w_valid <= 1'b0;
        end
      end
`endif
    end
  end

  assign K       = k_q;
  assign B       = b_q;
  assign rows    = rows_q;
  assign cols    = cols_q;
  assign err_cfg = err_cfg_q;

  // While loading the banks see write addresses; once DONE they serve the read ports.
  always_comb begin
    w_wr_addr = WA_BITS'(ch) * WA_BITS'(MAXK * MAXK) + WA_BITS'(e);
    x_wr_addr = XA_BITS'(ch) * XA_BITS'(PLANE) + XA_BITS'(r) * XA_BITS'(MAXC) + XA_BITS'(c);
    w_rd_full = WA_BITS'(w_rd_ch) * WA_BITS'(MAXK * MAXK) + WA_BITS'(w_rd_addr);
    x_rd_full = XA_BITS'(x_rd_ch) * XA_BITS'(PLANE) + XA_BITS'(x_rd_addr);
    w_addr    = s_axis_tready ? w_wr_addr : w_rd_full;
    x_addr    = s_axis_tready ? x_wr_addr : x_rd_full;
  end

  loader_bank #(
    .WIDTH (INW),
    .DEPTH (NCH * PLANE)
  ) u_x_bank (
    .clk   (clk),
    .we    (x_beat),
    .addr  (x_addr),
    .wdata (s_axis_tdata),
    .rdata (x_rd_data)
  );

  loader_bank #(
    .WIDTH (INW),
    .DEPTH (NCH * MAXK * MAXK)
  ) u_w_bank (
    .clk   (clk),
    .we    (w_beat),
    .addr  (w_addr),
    .wdata (s_axis_tdata),
    .rdata (w_rd_data)
  );

endmodule
